led_frame_ctrl: RTL
===================

Name: led_frame_ctrl

Overview:
- Sequences one LED-string frame, received over SPI, onto a single-wire WS2812-style data line.
- Monitors the SPI `load` strobe in the clk domain. On the falling edge of `load` (frame shift-in complete), snapshots the parallel frame word and serializes it MSB first with per-bit high/low timing.
- Holds the line low for the latch interval after each frame, then reports done.
- Sits between the SPI receive register (frame source) and the LED output pin.

Parameters:
- N_LEDS, 18, number of LEDs in the string
- BITS_PER_LED, 24, bits per LED (GRB, 8 each)
- TBIT_CYC, 60, clk cycles per data bit (1.25 us at 48 MHz)
- T0H_CYC, 19, high-time cycles for a '0' bit
- T1H_CYC, 38, high-time cycles for a '1' bit
- TRST_CYC, 14400, low latch/reset cycles after a frame (300 us at 48 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  SPI load strobe, asynchronous to clk; frame valid after its falling edge
- frame_in  in  N_LEDS*BITS_PER_LED (432)  frame from SPI register, bit [431] sent first; stable while load low
- led_dout  out  1  serial LED data line
- busy  out  1  high from frame capture through frame_done cycle
- frame_done  out  1  one-cycle pulse when latch interval ends

Behaviour:
- Reset: clk is clk; reset is rst_n, asynchronous, active-low. While reset is asserted:
  - led_dout=0, busy=0, frame_done=0
  - state=IDLE, pending=0, bit counter=0, cycle counter=0, shadow frame=0
  - sync flops reset to 1 (load idles high), so no false edge at release
- Sync: load passes through 2 flops. A falling edge is detected when sync2=1 and sync1=0 is registered, giving start_req, one pulse. Latency from load fall to start_req is 2-3 clk.
- States are IDLE, HIGH, LOW, LATCH.
- IDLE:
  - On start_req (or pending=1), capture frame_in into a 432-bit shadow register.
  - Clear pending, set bit index to 431 and cycle counter to 0.
  - Set busy=1 and go to HIGH. led_dout rises on the next cycle.
- HIGH:
  - led_dout=1 for THx = (shadow[idx] ? T1H_CYC : T0H_CYC) cycles, then go to LOW.
- LOW:
  - led_dout=0 for TBIT_CYC-THx cycles.
  - Then, if idx=0, go to LATCH with the cycle counter cleared.
  - Otherwise decrement idx and go to HIGH.
  - Each bit therefore spans exactly TBIT_CYC cycles with no gap between bits.
- LATCH:
  - led_dout=0 for TRST_CYC cycles.
  - Then assert frame_done for 1 cycle (busy still 1 in that cycle) and go to IDLE.
  - busy drops in the following cycle unless pending restarts immediately.
- start_req while busy: set pending=1. Multiple requests collapse into one. The frame is not re-captured until the next IDLE entry, and the in-progress frame is never disturbed.
- start_req in the same cycle as frame_done: set pending; the next IDLE cycle starts a new frame.
- frame_in changes while busy: ignored (shadow copy only).
- Reset mid-frame: led_dout drops to 0 immediately (asynchronously) and all state clears. No frame_done is issued.
- Total frame length: N_LEDS*BITS_PER_LED*TBIT_CYC + TRST_CYC cycles from the first led_dout rise to frame_done.
- Counters are sized with $clog2 of the largest count. Widths: cycle counter max(TBIT_CYC,TRST_CYC), bit index N_LEDS*BITS_PER_LED.
- Elaboration requirements: T0H_CYC < T1H_CYC < TBIT_CYC and T0H_CYC >= 1, else $error at elaboration.

Decomposition:
- Package led_pkg: default timing constants (48 MHz), FRAME_BITS = N_LEDS*BITS_PER_LED, and the state enum typedef led_state_t {IDLE, HIGH, LOW, LATCH}.
- Sub-module sync_fall_detect: 2-flop synchronizer plus registered falling-edge pulse, reset value 1. It is reused for other SPI strobes.

Test Plan:
All scenarios use N_LEDS=1, BITS_PER_LED=8, TBIT_CYC=10, T0H_CYC=3, T1H_CYC=6, TRST_CYC=20.
1. Reset check: hold rst_n=0 with load toggling → led_dout=0, busy=0, frame_done=0. Release with load=1 → no start.
2. Single frame: frame_in=8'hA5, pulse load low → led_dout pattern per bit is 1: 6 high/4 low, 0: 3 high/7 low, in order 1,0,1,0,0,1,0,1. Then 20 low cycles, frame_done pulses once, exactly 100 cycles after the first rise.
3. Mid-frame capture: start with 8'hFF, change frame_in to 8'h00 during bit 3 → all 8 bits are still '1' (6/4 timing).
4. Pending: pulse load twice during the first frame (8'h80), set frame_in=8'h01 before the first frame ends → exactly one second frame sends 8'h01 right after the frame_done cycle; busy has no gap.
5. Reset mid-operation: assert rst_n=0 during HIGH of bit 5 → led_dout=0 in the same cycle. After release, idle with no frame_done.
6. Edge timing: load fall → led_dout rise within 3-4 clk. Load glitch held high (no fall) → no activity.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: default WS2812 timing at 48 MHz and the frame sequencer state type
package led_pkg;

    localparam int N_LEDS_DEF       = 18;
    localparam int BITS_PER_LED_DEF = 24;
    localparam int TBIT_CYC_DEF     = 60;
    localparam int T0H_CYC_DEF      = 19;
    localparam int T1H_CYC_DEF      = 38;
    localparam int TRST_CYC_DEF     = 14400;
    localparam int FRAME_BITS       = N_LEDS_DEF * BITS_PER_LED_DEF;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } led_state_t;

endpackage

// File: rtl/sync_fall_detect.sv
// sync_fall_detect: two-flop synchronizer with a registered one-cycle falling-edge pulse
module sync_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);
    logic sync1, sync2;

    // synchronizer idles high so reset release never looks like a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            fall  <= sync2 & ~sync1;
        end
    end

endmodule

// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: serializes a captured SPI frame onto a WS2812-style data line
module led_frame_ctrl
    import led_pkg::*;
#(
    parameter int N_LEDS       = N_LEDS_DEF,
    parameter int BITS_PER_LED = BITS_PER_LED_DEF,
    parameter int TBIT_CYC     = TBIT_CYC_DEF,
    parameter int T0H_CYC      = T0H_CYC_DEF,
    parameter int T1H_CYC      = T1H_CYC_DEF,
    parameter int TRST_CYC     = TRST_CYC_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic [N_LEDS*BITS_PER_LED-1:0] frame_in,
    output logic                           led_dout,
    output logic                           busy,
    output logic                           frame_done
);
    localparam int FB   = N_LEDS * BITS_PER_LED;
    localparam int IW   = (FB > 1) ? $clog2(FB) : 1;
    localparam int CMAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] T0H_END  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T1H_END  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] T0L_END  = CW'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CW-1:0] T1L_END  = CW'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CW-1:0] TRST_END = CW'(TRST_CYC - 1);

    if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
        $error("led_frame_ctrl: timing requires 1 <= T0H_CYC < T1H_CYC < TBIT_CYC");
    end

    led_state_t    state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FB-1:0] shadow;
    logic          pending, pend_n;
    logic          start_req, cap, done_n, bit_one;
    logic [CW-1:0] hi_end, lo_end;

    sync_fall_detect u_load_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (load),
        .fall  (start_req)
    );

    assign bit_one = shadow[idx];
    assign hi_end  = bit_one ? T1H_END : T0H_END;
    assign lo_end  = bit_one ? T1L_END : T0L_END;

    // next-state: high phase, low phase per bit, then the latch gap; requests while busy collapse into pending
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        pend_n  = pending | start_req;
        cap     = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start_req || pending) begin
                    cap     = 1'b1;
                    pend_n  = 1'b0;
                    idx_n   = IW'(FB - 1);
                    state_n = HIGH;
                end
            end
            HIGH: if (cnt == hi_end) begin
                cnt_n   = '0;
                state_n = LOW;
            end
            LOW: if (cnt == lo_end) begin
                cnt_n = '0;
                if (idx == '0) state_n = LATCH;
                else begin
                    idx_n   = idx - IW'(1);
                    state_n = HIGH;
                end
            end
            LATCH: if (cnt == TRST_END) begin
                cnt_n   = '0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    // state, counters, shadow frame and glitch-free registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            shadow     <= '0;
            led_dout   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            pending    <= pend_n;
            if (cap) shadow <= frame_in;
            led_dout   <= (state_n == HIGH);
            busy       <= (state_n != IDLE) || done_n;
            frame_done <= done_n;
        end
    end

endmodule
